// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - two-master (fetch/data) single-bus arbiter with wait-timeout
// Data access wins ties; a flushed fetch still completes on the bus but is silently discarded.
module bus_arbiter #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ready,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [3:0]  mem_sel,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        mem_ready,
  output logic        bus_req,
  output logic        bus_we,
  output logic [3:0]  bus_sel,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack,
  input  logic        flush,
  output logic        stall_all,
  output logic        bus_timeout
);

  typedef enum logic [1:0] {S_IDLE, S_IF_BUSY, S_MEM_BUSY, S_DONE} state_t;

  localparam logic [7:0] LP_TMO = 8'(TIMEOUT);

  state_t      r_state, w_state_nxt;
  logic        r_bus_req, r_bus_we;
  logic [3:0]  r_bus_sel;
  logic [31:0] r_bus_addr, r_bus_wdata;
  logic [31:0] r_if_rdata, r_mem_rdata;
  logic        r_if_ready, r_mem_ready, r_timeout;
  logic [7:0]  r_cnt;
  logic        r_drop;
  logic        w_grant_mem, w_grant_if, w_ack, w_tmo, w_busy;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant_mem = 1'b0;
    w_grant_if  = 1'b0;
    w_ack       = 1'b0;
    w_tmo       = 1'b0;
    w_busy      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (mem_req) begin
          w_grant_mem = 1'b1;
          w_state_nxt = S_MEM_BUSY;
        end else if (if_req && !flush) begin
          w_grant_if  = 1'b1;
          w_state_nxt = S_IF_BUSY;
        end
      end
      S_IF_BUSY, S_MEM_BUSY: begin
        w_busy = 1'b1;
        // An ack arriving on the limit cycle still counts as success.
        if (bus_ack) begin
          w_ack       = 1'b1;
          w_state_nxt = S_DONE;
        end else if (r_cnt == LP_TMO) begin
          w_tmo       = 1'b1;
          w_state_nxt = S_DONE;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_bus_req   <= 1'b0;
      r_bus_we    <= 1'b0;
      r_bus_sel   <= 4'h0;
      r_bus_addr  <= 32'h0;
      r_bus_wdata <= 32'h0;
      r_if_rdata  <= 32'h0;
      r_mem_rdata <= 32'h0;
      r_if_ready  <= 1'b0;
      r_mem_ready <= 1'b0;
      r_timeout   <= 1'b0;
      r_cnt       <= 8'h0;
      r_drop      <= 1'b0;
    end else begin
      r_if_ready  <= 1'b0;
      r_mem_ready <= 1'b0;
      r_timeout   <= 1'b0;
      if (w_grant_mem) begin
        r_bus_req   <= 1'b1;
        r_bus_we    <= mem_we;
        r_bus_sel   <= mem_sel;
        r_bus_addr  <= mem_addr;
        r_bus_wdata <= mem_wdata;
        r_cnt       <= 8'h0;
      end else if (w_grant_if) begin
        r_bus_req   <= 1'b1;
        r_bus_we    <= 1'b0;
        r_bus_sel   <= 4'hf;
        r_bus_addr  <= if_addr;
        r_bus_wdata <= 32'h0;
        r_cnt       <= 8'h0;
      end
      if (w_ack || w_tmo) begin
        r_bus_req <= 1'b0;
        r_timeout <= w_tmo;
        if (r_state == S_IF_BUSY) begin
          // A flush in the completing cycle discards the fetch as well.
          if (!(r_drop || flush)) begin
            r_if_ready <= 1'b1;
            r_if_rdata <= w_ack ? bus_rdata : 32'h0;
          end
        end else begin
          r_mem_ready <= 1'b1;
          if (w_tmo)
            r_mem_rdata <= 32'h0;
          else if (!r_bus_we)
            r_mem_rdata <= bus_rdata;
        end
      end else if (w_busy) begin
        r_cnt <= r_cnt + 8'h1;
      end
      if (r_state == S_IF_BUSY && flush)
        r_drop <= 1'b1;
      else if (r_state == S_DONE)
        r_drop <= 1'b0;
    end
  end

  assign bus_req     = r_bus_req;
  assign bus_we      = r_bus_we;
  assign bus_sel     = r_bus_sel;
  assign bus_addr    = r_bus_addr;
  assign bus_wdata   = r_bus_wdata;
  assign if_rdata    = r_if_rdata;
  assign if_ready    = r_if_ready;
  assign mem_rdata   = r_mem_rdata;
  assign mem_ready   = r_mem_ready;
  assign bus_timeout = r_timeout;
  assign stall_all   = (mem_req && !r_mem_ready) || (if_req && !r_if_ready && !flush);

endmodule

// File: tb/tb_bus_arbiter.sv
// tb/tb_bus_arbiter.sv - self-checking bench for bus_arbiter
// Model tracks each master's last delivered word and arbitration order from the rules directly.
module tb_bus_arbiter;

  localparam int TMO = 255;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, mem_req, mem_we, bus_ack, flush;
  logic [31:0] if_addr, mem_addr, mem_wdata, bus_rdata;
  logic [3:0]  mem_sel;
  logic [31:0] if_rdata, mem_rdata, bus_addr, bus_wdata;
  logic        if_ready, mem_ready, bus_req, bus_we, stall_all, bus_timeout;
  logic [3:0]  bus_sel;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_if_rdata  = 32'h0;
  logic [31:0] exp_mem_rdata = 32'h0;

  always #5 clk = ~clk;

  bus_arbiter #(.TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_sel(mem_sel), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .bus_req(bus_req), .bus_we(bus_we), .bus_sel(bus_sel), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack),
    .flush(flush), .stall_all(stall_all), .bus_timeout(bus_timeout)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_bus_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus_req === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; if_req = 0; mem_req = 0; mem_we = 0; bus_ack = 0; flush = 0;
    if_addr = 0; mem_addr = 0; mem_wdata = 0; bus_rdata = 0; mem_sel = 0;
    #2;
    n_checks++;
    if ({bus_req, bus_we, if_ready, mem_ready, bus_timeout, stall_all} !== 6'b0) begin
      n_fail++; $display("FAIL reset_ctrl: got %b expected 000000",
        {bus_req, bus_we, if_ready, mem_ready, bus_timeout, stall_all});
    end
    n_checks++;
    if ({bus_sel, bus_addr, bus_wdata, if_rdata, mem_rdata} !== 132'h0) begin
      n_fail++; $display("FAIL reset_data: got sel=%h addr=%h wdata=%h ifr=%h memr=%h expected all 0",
        bus_sel, bus_addr, bus_wdata, if_rdata, mem_rdata);
    end
    tick(); tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_fetch();
    bit ok;
    if_addr = 32'hbfc00000; if_req = 1'b1;
    wait_bus_req(ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL fetch_grant: got no bus_req expected bus_req=1"); end
    n_checks++;
    if (bus_addr !== 32'hbfc00000 || bus_we !== 1'b0) begin
      n_fail++; $display("FAIL fetch_addr: got %h we=%b expected bfc00000 we=0", bus_addr, bus_we);
    end
    tick(); tick();
    n_checks++;
    if (bus_req !== 1'b1 || bus_addr !== 32'hbfc00000) begin
      n_fail++; $display("FAIL fetch_hold: got req=%b addr=%h expected 1 bfc00000", bus_req, bus_addr);
    end
    bus_ack = 1'b1; bus_rdata = 32'h3c080001;
    tick();
    bus_ack = 1'b0;
    exp_if_rdata = 32'h3c080001;
    n_checks++;
    if ({if_ready, mem_ready, bus_req, stall_all} !== 4'b1000) begin
      n_fail++; $display("FAIL fetch_done: got ifr/memr/req/stall=%b expected 1000",
        {if_ready, mem_ready, bus_req, stall_all});
    end
    n_checks++;
    if (if_rdata !== exp_if_rdata) begin
      n_fail++; $display("FAIL fetch_rdata: got %h expected %h", if_rdata, exp_if_rdata);
    end
    if_req = 1'b0;
    tick();
    n_checks++;
    if (if_ready !== 1'b0 || stall_all !== 1'b0) begin
      n_fail++; $display("FAIL fetch_pulse: got ready=%b stall=%b expected 0 0", if_ready, stall_all);
    end
  endtask

  task automatic test_priority();
    bit ok;
    logic [31:0] ia, rd;
    ia = $urandom;
    if_addr = ia; if_req = 1'b1;
    mem_we = 1'b1; mem_sel = 4'hf; mem_addr = 32'h80000010; mem_wdata = 32'hdeadbeef; mem_req = 1'b1;
    wait_bus_req(ok);
    n_checks++;
    if (!ok || bus_addr !== 32'h80000010 || bus_we !== 1'b1 || bus_sel !== 4'hf || bus_wdata !== 32'hdeadbeef) begin
      n_fail++; $display("FAIL prio_mem_first: got ok=%b addr=%h we=%b sel=%h wdata=%h expected 80000010 1 f deadbeef",
        ok, bus_addr, bus_we, bus_sel, bus_wdata);
    end
    bus_ack = 1'b1; bus_rdata = $urandom;
    tick();
    bus_ack = 1'b0;
    n_checks++;
    if ({mem_ready, if_ready} !== 2'b10 || mem_rdata !== exp_mem_rdata) begin
      n_fail++; $display("FAIL prio_mem_done: got memr=%b ifr=%b mem_rdata=%h expected 1 0 %h",
        mem_ready, if_ready, mem_rdata, exp_mem_rdata);
    end
    mem_req = 1'b0;
    tick();
    n_checks++;
    if (bus_req !== 1'b0) begin
      n_fail++; $display("FAIL prio_done_gap: got bus_req=%b expected 0", bus_req);
    end
    wait_bus_req(ok);
    n_checks++;
    if (!ok || bus_addr !== ia || bus_we !== 1'b0) begin
      n_fail++; $display("FAIL prio_fetch_next: got ok=%b addr=%h we=%b expected %h 0", ok, bus_addr, bus_we, ia);
    end
    rd = $urandom;
    bus_ack = 1'b1; bus_rdata = rd;
    tick();
    bus_ack = 1'b0;
    exp_if_rdata = rd;
    n_checks++;
    if (if_ready !== 1'b1 || if_rdata !== exp_if_rdata) begin
      n_fail++; $display("FAIL prio_fetch_done: got ready=%b rdata=%h expected 1 %h", if_ready, if_rdata, exp_if_rdata);
    end
    if_req = 1'b0;
    tick();
  endtask

  task automatic test_flush();
    bit ok;
    logic [31:0] rd;
    if_addr = $urandom; if_req = 1'b1;
    wait_bus_req(ok);
    flush = 1'b1;
    #1;
    n_checks++;
    if (!ok || stall_all !== 1'b0) begin
      n_fail++; $display("FAIL flush_stall: got ok=%b stall=%b expected 1 0", ok, stall_all);
    end
    tick();
    flush = 1'b0; if_req = 1'b0;
    tick();
    bus_ack = 1'b1; bus_rdata = 32'h12345678;
    tick();
    bus_ack = 1'b0;
    n_checks++;
    if (if_ready !== 1'b0 || if_rdata !== exp_if_rdata || bus_req !== 1'b0) begin
      n_fail++; $display("FAIL flush_drop: got ready=%b rdata=%h req=%b expected 0 %h 0",
        if_ready, if_rdata, bus_req, exp_if_rdata);
    end
    tick(); tick();
    rd = $urandom;
    if_addr = $urandom; if_req = 1'b1;
    wait_bus_req(ok);
    bus_ack = 1'b1; bus_rdata = rd;
    tick();
    bus_ack = 1'b0;
    exp_if_rdata = rd;
    n_checks++;
    if (!ok || if_ready !== 1'b1 || if_rdata !== exp_if_rdata) begin
      n_fail++; $display("FAIL flush_recover: got ok=%b ready=%b rdata=%h expected 1 1 %h",
        ok, if_ready, if_rdata, exp_if_rdata);
    end
    if_req = 1'b0;
    tick();
  endtask

  task automatic test_ack_ignored();
    bus_ack = 1'b1; bus_rdata = $urandom;
    tick(); tick(); tick();
    n_checks++;
    if ({bus_req, if_ready, mem_ready} !== 3'b0 || if_rdata !== exp_if_rdata || mem_rdata !== exp_mem_rdata) begin
      n_fail++; $display("FAIL idle_ack: got req/ifr/memr=%b ifd=%h memd=%h expected 000 %h %h",
        {bus_req, if_ready, mem_ready}, if_rdata, mem_rdata, exp_if_rdata, exp_mem_rdata);
    end
    bus_ack = 1'b0;
  endtask

  task automatic test_random();
    bit ok, is_mem, mw;
    int mode, lat, nserve;
    logic [31:0] ma, md, ia, rd;
    logic [3:0] ms;
    for (int it = 0; it < 40; it++) begin
      mode = int'($urandom_range(0, 2));
      ma = $urandom; md = $urandom; ia = $urandom;
      ms = 4'($urandom_range(1, 15)); mw = 1'($urandom_range(0, 1));
      mem_addr = ma; mem_wdata = md; mem_sel = ms; mem_we = mw; if_addr = ia;
      mem_req = (mode != 1); if_req = (mode != 0);
      #1;
      n_checks++;
      if (stall_all !== 1'b1) begin
        n_fail++; $display("FAIL rnd_stall it=%0d: got %b expected 1", it, stall_all);
      end
      nserve = (mode == 2) ? 2 : 1;
      for (int k = 0; k < nserve; k++) begin
        is_mem = (mode == 0) || (mode == 2 && k == 0);
        wait_bus_req(ok);
        n_checks++;
        if (!ok || bus_addr !== (is_mem ? ma : ia) || bus_we !== (is_mem ? mw : 1'b0)) begin
          n_fail++; $display("FAIL rnd_grant it=%0d k=%0d: got ok=%b addr=%h we=%b expected %h %b",
            it, k, ok, bus_addr, bus_we, is_mem ? ma : ia, is_mem ? mw : 1'b0);
        end
        if (is_mem) begin
          n_checks++;
          if (bus_sel !== ms || bus_wdata !== md) begin
            n_fail++; $display("FAIL rnd_mem_fields it=%0d: got sel=%h wdata=%h expected %h %h",
              it, bus_sel, bus_wdata, ms, md);
          end
        end
        lat = int'($urandom_range(0, 4));
        repeat (lat) tick();
        n_checks++;
        if (bus_req !== 1'b1 || bus_addr !== (is_mem ? ma : ia)) begin
          n_fail++; $display("FAIL rnd_stable it=%0d: got req=%b addr=%h expected 1 %h",
            it, bus_req, bus_addr, is_mem ? ma : ia);
        end
        rd = $urandom;
        bus_ack = 1'b1; bus_rdata = rd;
        tick();
        bus_ack = 1'b0;
        if (is_mem && !mw) exp_mem_rdata = rd;
        if (!is_mem) exp_if_rdata = rd;
        n_checks++;
        if ({if_ready, mem_ready} !== (is_mem ? 2'b01 : 2'b10) || bus_req !== 1'b0 || bus_timeout !== 1'b0) begin
          n_fail++; $display("FAIL rnd_ready it=%0d: got ifr/memr=%b req=%b tmo=%b expected %b 0 0",
            it, {if_ready, mem_ready}, bus_req, bus_timeout, is_mem ? 2'b01 : 2'b10);
        end
        n_checks++;
        if (if_rdata !== exp_if_rdata || mem_rdata !== exp_mem_rdata) begin
          n_fail++; $display("FAIL rnd_rdata it=%0d: got if=%h mem=%h expected %h %h",
            it, if_rdata, mem_rdata, exp_if_rdata, exp_mem_rdata);
        end
        if (is_mem) mem_req = 1'b0;
        else        if_req  = 1'b0;
        tick();
        n_checks++;
        if ({if_ready, mem_ready, bus_req} !== 3'b0) begin
          n_fail++; $display("FAIL rnd_after it=%0d: got ifr/memr/req=%b expected 000",
            it, {if_ready, mem_ready, bus_req});
        end
      end
    end
  endtask

  task automatic test_timeout();
    bit ok;
    int cnt;
    mem_we = 1'b0; mem_addr = $urandom; mem_req = 1'b1;
    wait_bus_req(ok);
    bus_ack = 1'b1; bus_rdata = 32'hcafef00d;
    tick();
    bus_ack = 1'b0; mem_req = 1'b0;
    exp_mem_rdata = 32'hcafef00d;
    tick();
    mem_addr = $urandom; mem_req = 1'b1;
    wait_bus_req(ok);
    cnt = 0;
    while (bus_req === 1'b1 && cnt < 300) begin
      cnt++;
      tick();
    end
    exp_mem_rdata = 32'h0;
    n_checks++;
    if (cnt != TMO + 1) begin
      n_fail++; $display("FAIL tmo_cycles: got %0d expected %0d", cnt, TMO + 1);
    end
    n_checks++;
    if ({mem_ready, bus_timeout, bus_req, if_ready} !== 4'b1100 || mem_rdata !== exp_mem_rdata) begin
      n_fail++; $display("FAIL tmo_report: got memr/tmo/req/ifr=%b rdata=%h expected 1100 %h",
        {mem_ready, bus_timeout, bus_req, if_ready}, mem_rdata, exp_mem_rdata);
    end
    mem_req = 1'b0;
    tick();
    n_checks++;
    if (bus_timeout !== 1'b0 || mem_ready !== 1'b0) begin
      n_fail++; $display("FAIL tmo_pulse: got tmo=%b ready=%b expected 0 0", bus_timeout, mem_ready);
    end
  endtask

  task automatic test_ack_at_limit();
    bit ok;
    logic [31:0] rd;
    rd = $urandom | 32'h1;
    mem_we = 1'b0; mem_addr = $urandom; mem_req = 1'b1;
    wait_bus_req(ok);
    repeat (TMO) tick();
    bus_ack = 1'b1; bus_rdata = rd;
    tick();
    bus_ack = 1'b0;
    exp_mem_rdata = rd;
    n_checks++;
    if (!ok || mem_ready !== 1'b1 || bus_timeout !== 1'b0 || mem_rdata !== exp_mem_rdata) begin
      n_fail++; $display("FAIL ack_at_limit: got ok=%b ready=%b tmo=%b rdata=%h expected 1 1 0 %h",
        ok, mem_ready, bus_timeout, mem_rdata, exp_mem_rdata);
    end
    mem_req = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    bit ok;
    logic [31:0] rd;
    mem_we = 1'b0; mem_addr = $urandom; mem_req = 1'b1;
    wait_bus_req(ok);
    tick();
    #2;
    rst = 1'b0;
    #1;
    exp_if_rdata = 32'h0; exp_mem_rdata = 32'h0;
    n_checks++;
    if (!ok || {bus_req, bus_we, if_ready, mem_ready, bus_timeout} !== 5'b0) begin
      n_fail++; $display("FAIL rstmid_ctrl: got ok=%b req/we/ifr/memr/tmo=%b expected 1 00000",
        ok, {bus_req, bus_we, if_ready, mem_ready, bus_timeout});
    end
    n_checks++;
    if ({bus_sel, bus_addr, bus_wdata, if_rdata, mem_rdata} !== 132'h0) begin
      n_fail++; $display("FAIL rstmid_data: got sel=%h addr=%h wdata=%h ifr=%h memr=%h expected all 0",
        bus_sel, bus_addr, bus_wdata, if_rdata, mem_rdata);
    end
    bus_ack = 1'b1;
    tick(); tick();
    bus_ack = 1'b0;
    n_checks++;
    if (mem_ready !== 1'b0 || bus_req !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_hold: got ready=%b req=%b expected 0 0", mem_ready, bus_req);
    end
    rst = 1'b1;
    tick();
    n_checks++;
    if (bus_req !== 1'b1 || mem_ready !== 1'b0 || bus_addr !== mem_addr) begin
      n_fail++; $display("FAIL rstmid_regrant: got req=%b ready=%b addr=%h expected 1 0 %h",
        bus_req, mem_ready, bus_addr, mem_addr);
    end
    rd = $urandom;
    bus_ack = 1'b1; bus_rdata = rd;
    tick();
    bus_ack = 1'b0;
    exp_mem_rdata = rd;
    n_checks++;
    if (mem_ready !== 1'b1 || mem_rdata !== exp_mem_rdata) begin
      n_fail++; $display("FAIL rstmid_done: got ready=%b rdata=%h expected 1 %h", mem_ready, mem_rdata, exp_mem_rdata);
    end
    mem_req = 1'b0;
    tick();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_fetch();
    test_priority();
    test_flush();
    test_ack_ignored();
    test_random();
    test_timeout();
    test_ack_at_limit();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 SHALL have ports: clk  in  1  clock, all state on rising edge.
REQ-002 SHALL have ports: rst  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have ports: if_req  in  1  fetch request; if_addr  in  32  fetch address.
REQ-004 SHALL have ports: if_rdata  out  32  fetched word; if_ready  out  1  one-cycle fetch-done pulse.
REQ-005 SHALL have ports: mem_req  in  1; mem_we  in  1; mem_sel  in  4  byte enables; mem_addr  in  32; mem_wdata  in  32.
REQ-006 SHALL have ports: mem_rdata  out  32; mem_ready  out  1  one-cycle data-done pulse.
REQ-007 SHALL have ports: bus_req, bus_we  out  1; bus_sel  out  4; bus_addr, bus_wdata  out  32; bus_rdata  in  32; bus_ack  in  1.
REQ-008 SHALL have ports: flush  in  1  pipeline flush; stall_all  out  1  to pipeline controller; bus_timeout  out  1  one-cycle error pulse.
REQ-009 SHALL have parameter TIMEOUT, default 255, max bus wait cycles (8-bit counter).

Function
REQ-010 SHALL implement FSM states IDLE, IF_BUSY, MEM_BUSY, DONE.
REQ-011 In IDLE, mem_req SHALL win over if_req when both high (data access belongs to older instruction).
REQ-012 On grant, SHALL latch address, we, sel, wdata into bus_* registers and assert bus_req next cycle; transition IDLE->IF_BUSY or IDLE->MEM_BUSY.
REQ-013 bus_req and all bus_* outputs SHALL stay stable until the cycle bus_ack is sampled high.
REQ-014 On bus_ack in X_BUSY: SHALL deassert bus_req next cycle, capture bus_rdata into the granted master's rdata register, pulse that master's ready for exactly one cycle, go to DONE.
REQ-015 DONE SHALL last one cycle then return to IDLE; no back-to-back grant in DONE (lets master drop req).
REQ-016 For writes, mem_rdata SHALL hold its previous value; mem_ready still pulses.
REQ-017 if_rdata/mem_rdata SHALL hold last captured value until next completion of that master.
REQ-018 Wait counter SHALL clear on grant, increment each X_BUSY cycle without bus_ack; at count == TIMEOUT with no ack, SHALL drop bus_req, return rdata 32'h0, pulse ready and bus_timeout together, go to DONE.
REQ-019 bus_ack in the same cycle the counter reaches TIMEOUT SHALL be treated as success (no bus_timeout).
REQ-020 flush during IF_BUSY SHALL NOT abort the bus cycle; on its completion if_ready SHALL be suppressed and if_rdata not updated (drop flag set by flush, cleared on entering IDLE).
REQ-021 flush during MEM_BUSY SHALL have no effect (data access completes and reports).
REQ-022 flush in IDLE SHALL block an if_req grant in that cycle; mem_req grant unaffected.
REQ-023 stall_all SHALL be combinational: high when (mem_req and not mem_ready) or (if_req and not if_ready and not flush); low otherwise.
REQ-024 bus_ack received in IDLE or DONE SHALL be ignored.
REQ-025 if_req and mem_req SHALL be level requests; a master holding req after its ready pulse is re-arbitrated in IDLE as a new transaction.

Reset
REQ-026 On rst low, SHALL asynchronously enter IDLE; bus_req, bus_we, if_ready, mem_ready, bus_timeout = 0; bus_sel = 4'h0; bus_addr, bus_wdata, if_rdata, mem_rdata = 32'h0; counter and drop flag = 0.
REQ-027 Reset mid-transaction SHALL drop bus_req immediately with no ready pulse; after release, first active edge evaluates IDLE arbitration.

Verification
REQ-028 if_req=1, if_addr=32'hbfc00000, bus_ack after 2 cycles with bus_rdata=32'h3c080001 -> bus_addr=32'hbfc00000, if_ready one pulse, if_rdata=32'h3c080001, stall_all low after pulse.
REQ-029 if_req and mem_req (we=1, sel=4'hf, addr=32'h80000010, wdata=32'hdeadbeef) same cycle -> data write granted first, mem_ready pulse, then fetch granted after DONE.
REQ-030 flush pulsed in IF_BUSY, bus_ack later with bus_rdata=32'h12345678 -> no if_ready, if_rdata unchanged, FSM returns to IDLE.
REQ-031 mem_req read, bus_ack never asserted -> after 255 wait cycles bus_timeout and mem_ready pulse together, mem_rdata=32'h0, bus_req low.
REQ-032 rst low during MEM_BUSY -> bus_req=0 same instant, no mem_ready pulse, all outputs at reset values.
